// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses rx byte frames into one ALU operation
// and returns the double-width result as two tx bytes, LSB first.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]              alu_fun,
  output logic                    alu_en,
  output logic                    alu_clk_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    err
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [DW-1:0] CMD_NEW = DW'(8'hCC);
  localparam logic [DW-1:0] CMD_OLD = DW'(8'hDD);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    WAIT_RES,
    SEND_LO,
    SEND_HI
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    fun_q, fun_d;
  logic [RW-1:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          alu_en_q, alu_en_d;
  logic          clk_en_q, clk_en_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (rx_data == CMD_NEW): state_d = GET_A;
            (rx_data == CMD_OLD): state_d = GET_FUN;
            default:              state_d = IDLE;
          endcase
        end
      end
      GET_A: begin
        if (rx_valid) begin
          a_d     = rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (rx_valid) begin
          b_d     = rx_data;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (rx_valid) begin
          fun_d   = rx_data[3:0];
          state_d = ALU_RUN;
        end
      end
      ALU_RUN: begin
        cnt_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        cnt_d = cnt_q + 1'b1;
        // a valid on the last counted cycle still beats the timeout
        if (alu_valid) begin
          res_d     = alu_out;
          tx_data_d = alu_out[DW-1:0];
          state_d   = SEND_LO;
        end else if (cnt_q == CNT_LAST) begin
          res_d     = '1;
          tx_data_d = '1;
          err_d     = 1'b1;
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          tx_data_d = res_q[RW-1:DW];
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    alu_en_d   = (state_d == ALU_RUN);
    clk_en_d   = (state_d == ALU_RUN) || (state_d == WAIT_RES);
    tx_valid_d = (state_d == SEND_LO) || (state_d == SEND_HI);
    busy_d     = clk_en_d || tx_valid_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      alu_en_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      alu_en_q   <= alu_en_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign busy       = busy_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_fun    = fun_q;
  assign alu_en     = alu_en_q;
  assign alu_clk_en = clk_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: frame-level reference model, behavioural ALU
// and transmit sink with programmable stalls.
module tb_alu_cmd_ctrl;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          busy;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic          alu_en, alu_clk_en;
  logic [15:0]   alu_out = '0;
  logic          alu_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          err;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_en(alu_en), .alu_clk_en(alu_clk_en),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model of stored operands
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  // observation
  logic [7:0] got_q[$];
  int en_cnt, ce_cnt, err_cnt;
  logic [7:0] en_a, en_b;
  logic [3:0] en_fun;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd = '0;

  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) chk("tx_hold", {tx_valid, tx_data}, {1'b1, pd});
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (alu_en) begin
        en_cnt++;
        en_a = alu_a;
        en_b = alu_b;
        en_fun = alu_fun;
      end
      if (alu_clk_en) ce_cnt++;
      if (err) err_cnt++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  // behavioural ALU: valid lat cycles after the enable, 0 = never
  int alu_lat = 1;
  logic [15:0] alu_val = '0;

  initial forever begin
    @(negedge CLK);
    if (RST && alu_en && alu_lat > 0) begin
      repeat (alu_lat) @(posedge CLK);
      #1 alu_valid = 1'b1;
      alu_out = alu_val;
      @(posedge CLK);
      #1 alu_valid = 1'b0;
      alu_out = 16'($urandom);
    end
  end

  // transmit sink: stall each byte for a programmed number of cycles
  int stall_lo = 0;
  int stall_hi = 0;

  initial forever begin
    @(posedge CLK);
    #1;
    if (tx_valid && got_q.size() == 0 && stall_lo > 0) begin
      tx_ready = 1'b0;
      stall_lo--;
    end else if (tx_valid && got_q.size() == 1 && stall_hi > 0) begin
      tx_ready = 1'b0;
      stall_hi--;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1 rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic frame(input bit cc, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] f, input int lat,
                       input logic [15:0] v, input int slo, input int shi,
                       input bit junk, input string tag);
    logic [15:0] exp;
    bit ok, tmo, seen;
    int cyc, lcy, wcy;
    got_q.delete();
    en_cnt = 0;
    ce_cnt = 0;
    err_cnt = 0;
    alu_lat = lat;
    alu_val = v;
    stall_lo = slo;
    stall_hi = shi;
    if (cc) begin
      send(8'hCC);
      send(a);
      send(b);
      m_a = a;
      m_b = b;
    end else begin
      send(8'hDD);
    end
    send(f);
    ok = (lat >= 1) && (lat <= TO);
    tmo = !ok;
    exp = ok ? v : 16'hFFFF;
    wcy = ok ? lat : TO;
    cyc = 0;
    lcy = 1;
    seen = 1'b0;
    while (!(got_q.size() == 2 && !busy) && cyc < 300) begin
      if (!seen) begin
        if (tx_valid) seen = 1'b1;
        else lcy++;
      end
      if (junk && busy) begin
        rx_data = 8'($urandom);
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      @(posedge CLK);
      #1 cyc++;
    end
    rx_valid = 1'b0;
    chk({tag, "_bound"}, 64'(cyc < 300), 64'(1));
    chk({tag, "_en_cnt"}, 64'(en_cnt), 64'(1));
    chk({tag, "_ops"}, {en_a, en_b, en_fun}, {m_a, m_b, f[3:0]});
    chk({tag, "_tx_cnt"}, 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2)
      chk({tag, "_tx_bytes"}, {got_q[1], got_q[0]}, exp);
    chk({tag, "_err"}, 64'(err_cnt), 64'(tmo));
    chk({tag, "_clk_en_cycles"}, 64'(ce_cnt), 64'(1 + wcy));
    chk({tag, "_latency"}, 64'(lcy), 64'(2 + wcy));
    chk({tag, "_idle"}, {busy, alu_clk_en, tx_valid, alu_a, alu_b},
        {3'b000, m_a, m_b});
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b0;
    #1;
    chk({tag, "_outs"},
        {busy, alu_a, alu_b, alu_fun, alu_en, alu_clk_en,
         tx_data, tx_valid, err}, '0);
    m_a = '0;
    m_b = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    @(posedge CLK);
    #1 do_reset("reset0");

    frame(1'b1, 8'h0F, 8'hF0, 8'h01, 1, 16'h00FF, 0, 0, 1'b0, "s1");
    frame(1'b0, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 0, 0, 1'b0, "s2");
    frame(1'b1, 8'hA5, 8'h5A, 8'h03, 1, 16'h1234, 5, 3, 1'b0, "s3");
    frame(1'b1, 8'h12, 8'h34, 8'h02, 0, 16'hBEEF, 0, 0, 1'b0, "s4");
    frame(1'b1, 8'h21, 8'h43, 8'h07, TO, 16'hC0DE, 0, 0, 1'b0, "lat_max");
    frame(1'b0, 8'h00, 8'h00, 8'hF9, TO + 1, 16'h5151, 1, 0, 1'b0,
          "lat_over");

    send(8'h55);
    chk("s5_idle_55", 64'(busy), 64'(0));
    send(8'h12);
    chk("s5_idle_12", 64'(busy), 64'(0));
    frame(1'b1, 8'h3C, 8'hC3, 8'h04, 2, 16'hA55A, 2, 1, 1'b1, "s5_junk");
    frame(1'b0, 8'h00, 8'h00, 8'h05, 1, 16'h0102, 0, 0, 1'b1, "s5_dd");

    got_q.delete();
    send(8'hCC);
    send(8'h0F);
    do_reset("s6_frame");
    chk("s6_frame_no_tx", 64'(got_q.size()), 64'(0));
    frame(1'b0, 8'h00, 8'h00, 8'h06, 1, 16'h7788, 0, 0, 1'b0, "s6_dd");

    got_q.delete();
    err_cnt = 0;
    alu_lat = 0;
    send(8'hCC);
    send(8'h11);
    send(8'h22);
    send(8'h03);
    repeat (5) @(posedge CLK);
    #1 chk("s6_in_wait", {busy, alu_clk_en}, 2'b11);
    do_reset("s6_wait");
    repeat (TO + 4) @(posedge CLK);
    #1 chk("s6_wait_quiet", {32'(got_q.size()), 32'(err_cnt)}, '0);
    chk("s6_wait_idle", {busy, tx_valid, alu_clk_en}, 3'b000);
    frame(1'b1, 8'h99, 8'h66, 8'h0A, 1, 16'hFACE, 0, 0, 1'b0, "s6_after");

    for (int i = 0; i < 24; i++) begin
      int lat;
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 2))
                                        : int'($urandom_range(1, 3));
      frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            8'($urandom), lat, 16'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) send(8'($urandom_range(0, 8'hCB)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
